turn_signal_input: RTL and testbench

TURN_SIGNAL_INPUT -- requirements
Module: turn_signal_input

---
 rtl/turn_signal_input.sv | 107 ++++++++++
 tb/tb_turn_signal_input.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/turn_signal_input.sv
// Turn-signal switch front end: synchronizes and debounces the left and
// right switch levels, then republishes them as mutually exclusive
// left/right requests (plus a conflict flag) once per update tick.
module turn_signal_input #(
  parameter int DEBOUNCE = 4,  // consecutive differing cycles before a change is accepted
  parameter int TICK_DIV = 8   // clock cycles per output update tick
) (
  input  logic clk,
  input  logic reset,      // asynchronous, active-low
  input  logic raw_left,
  input  logic raw_right,
  output logic left,
  output logic right,
  output logic conflict,
  output logic tick
);

  localparam int CW = $clog2(DEBOUNCE) + 1;
  localparam int TW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  // Channel 0 is left, channel 1 is right.
  logic [1:0] raw_in;
  logic [1:0] deb;

  assign raw_in = {raw_right, raw_left};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      logic [1:0]    sync_q, sync_d;
      logic          deb_q, deb_d;
      logic [CW-1:0] cnt_q, cnt_d;

      // Two-flop synchronizer shift plus debounce: count consecutive cycles
      // where the synchronized level disagrees with the accepted level.
      always_comb begin
        sync_d = {sync_q[0], raw_in[gi]};
        deb_d  = deb_q;
        cnt_d  = '0;
        if (sync_q[1] != deb_q) begin
          if (cnt_q == DB_LAST) begin
            deb_d = ~deb_q;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      // Channel state registers; reset also discards any partial count.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          sync_q <= '0;
          deb_q  <= 1'b0;
          cnt_q  <= '0;
        end else begin
          sync_q <= sync_d;
          deb_q  <= deb_d;
          cnt_q  <= cnt_d;
        end
      end

      assign deb[gi] = deb_q;
    end
  endgenerate

  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          left_q, left_d;
  logic          right_q, right_d;
  logic          conflict_q, conflict_d;

  assign tick = (tick_cnt_q == TICK_LAST);

  // Tick divider and output update: outputs only move on tick cycles, and
  // both channels active resolves to conflict with no direction asserted.
  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
    left_d     = left_q;
    right_d    = right_q;
    conflict_d = conflict_q;
    if (tick) begin
      left_d     = deb[0] & ~deb[1];
      right_d    = deb[1] & ~deb[0];
      conflict_d = deb[0] & deb[1];
    end
  end

  // Tick counter and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt_q <= '0;
      left_q     <= 1'b0;
      right_q    <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      left_q     <= left_d;
      right_q    <= right_d;
      conflict_q <= conflict_d;
    end
  end

  assign left     = left_q;
  assign right    = right_q;
  assign conflict = conflict_q;

endmodule

// File: tb/tb_turn_signal_input.sv
// Randomized and directed bench for turn_signal_input against a cycle-indexed
// history model of synchronize / debounce / tick-sampled outputs.
module tb_turn_signal_input;

  localparam int DEBOUNCE = 4;
  localparam int TICK_DIV = 8;
  localparam int MAXC     = 2048;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic raw_left = 1'b0;
  logic raw_right = 1'b0;
  logic left, right, conflict, tick;

  always #5 clk = ~clk;

  turn_signal_input #(.DEBOUNCE(DEBOUNCE), .TICK_DIV(TICK_DIV)) dut (
    .clk      (clk),
    .reset    (reset),
    .raw_left (raw_left),
    .raw_right(raw_right),
    .left     (left),
    .right    (right),
    .conflict (conflict),
    .tick     (tick)
  );

  int num_checks = 0;
  int num_fail   = 0;

  // Model: per-cycle raw history, accepted level, and the cycle at which the
  // accepted level last changed (a new differing run cannot start before it).
  logic raw_h  [2][MAXC];
  logic sync_h [2][MAXC];
  logic deb_m  [2];
  int   t_last [2];
  logic left_m, right_m, conf_m;
  int   hold   [2];
  logic rnd_val[2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Hold reset low over a few edges, then release just after a rising edge
  // so the following period is cycle 0.
  task automatic apply_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_left", left, 0);
    check_eq("rst_right", right, 0);
    check_eq("rst_conflict", conflict, 0);
    check_eq("rst_tick", tick, 0);
    for (int ch = 0; ch < 2; ch++) begin
      deb_m[ch]  = 1'b0;
      t_last[ch] = 0;
      hold[ch]   = 0;
    end
    left_m  = 1'b0;
    right_m = 1'b0;
    conf_m  = 1'b0;
    reset   = 1'b1;
  endtask

  function automatic logic stim(input int mode, input int n, input int ch);
    case (mode)
      1:       return (ch == 0) && (n < 20);  // press then release left
      2:       return (ch == 0);              // hold left
      3:       return (ch == 0) && (n < 3);   // short glitch on left
      4:       return 1'b1;                   // both held
      default: return 1'b0;                   // idle
    endcase
  endfunction

  // Spot checks of the specific cycle numbers the behaviour is defined by.
  task automatic directed_checks(input int mode, input int n);
    if (mode == 0 && n == 7)  check_eq("idle_tick7", tick, 1);
    if (mode == 0 && n == 15) check_eq("idle_tick15", tick, 1);
    if (mode == 0 && n == 16) check_eq("idle_tick16", tick, 0);
    if (mode == 1 && n == 7)  check_eq("press_left7", left, 0);
    if (mode == 1 && n == 8)  check_eq("press_left8", left, 1);
    if (mode == 1 && n == 31) check_eq("release_left31", left, 1);
    if (mode == 1 && n == 32) check_eq("release_left32", left, 0);
    if (mode == 2 && n == 7)  check_eq("hold_left7", left, 0);
    if (mode == 2 && n == 8)  check_eq("hold_left8", left, 1);
    if (mode == 3 && n == 40) check_eq("glitch_left40", left, 0);
    if (mode == 4 && n == 7)  check_eq("both_conf7", conflict, 0);
    if (mode == 4 && n == 8) begin
      check_eq("both_conf8", conflict, 1);
      check_eq("both_left8", left, 0);
      check_eq("both_right8", right, 0);
    end
  endtask

  // Run ncyc cycles from reset release; mode 5 draws random hold lengths.
  task automatic run_phase(input int mode, input int ncyc);
    bit all_diff;
    bit tick_m;
    for (int n = 0; n < ncyc; n++) begin
      for (int ch = 0; ch < 2; ch++) begin
        if (mode == 5) begin
          if (hold[ch] == 0) begin
            rnd_val[ch] = 1'($urandom_range(0, 1));
            hold[ch]    = int'($urandom_range(1, 12));
          end
          hold[ch]--;
          raw_h[ch][n] = rnd_val[ch];
        end else begin
          raw_h[ch][n] = stim(mode, n, ch);
        end
        sync_h[ch][n] = (n >= 2) ? raw_h[ch][n-2] : 1'b0;
      end
      raw_left  = raw_h[0][n];
      raw_right = raw_h[1][n];

      @(negedge clk);
      tick_m = ((n % TICK_DIV) == TICK_DIV - 1);
      check_eq("tick", tick, tick_m);
      check_eq("left", left, left_m);
      check_eq("right", right, right_m);
      check_eq("conflict", conflict, conf_m);
      check_eq("exclusive", left & right, 0);
      directed_checks(mode, n);

      // Outputs sample the accepted levels of this cycle on a tick.
      if (tick_m) begin
        left_m  = deb_m[0] & ~deb_m[1];
        right_m = deb_m[1] & ~deb_m[0];
        conf_m  = deb_m[0] & deb_m[1];
      end
      // Accept a change after DEBOUNCE consecutive disagreeing cycles that
      // all lie after the previous change.
      for (int ch = 0; ch < 2; ch++) begin
        if (n - DEBOUNCE + 1 >= t_last[ch]) begin
          all_diff = 1'b1;
          for (int k = n - DEBOUNCE + 1; k <= n; k++)
            if (sync_h[ch][k] == deb_m[ch]) all_diff = 1'b0;
          if (all_diff) begin
            deb_m[ch]  = ~deb_m[ch];
            t_last[ch] = n + 1;
          end
        end
      end

      @(posedge clk);
      #1;
    end
    $display("phase mode=%0d cycles=%0d checks=%0d failures=%0d", mode, ncyc, num_checks, num_fail);
  endtask

  initial begin
    apply_reset();
    run_phase(0, 30);
    apply_reset();
    run_phase(1, 40);
    apply_reset();
    run_phase(2, 30);
    check_eq("pre_midreset_left", left, 1);

    // Asynchronous reset between edges must clear outputs at once.
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_eq("midreset_left", left, 0);
    check_eq("midreset_tick", tick, 0);
    check_eq("midreset_conflict", conflict, 0);
    apply_reset();
    run_phase(2, 20);

    apply_reset();
    run_phase(3, 45);
    apply_reset();
    run_phase(4, 30);
    apply_reset();
    run_phase(5, 1500);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
    $finish;
  end

endmodule
